redmule_dequant_scheduler: RTL and testbench
============================================

Name: redmule_dequant_scheduler

Overview:
Sequences the three dequantization stream sources (group-ID, zeros, quantized weights) tile by tile during a dequant-mode GEMM. It sits beside the memory scheduler, drives the per-stream address-generator base addresses and req_start strobes, and consumes streamer ready_start/done flags. One start pulse from the main controller runs a full W sweep of n_tiles tiles. A group-ID word is reloaded every gid_period tiles.

Parameters:
AW, 32, address width (bytes)
CW, 16, tile/period counter width
JMP, 32, byte step between consecutive tile/GID words (NumByte*(DATA_W/MemDw-1) at top level)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
clear_i  in  1  sync clear, highest priority after reset
start_i  in  1  start pulse from controller
n_tiles_i  in  CW  tiles in sweep (W_ITERS[15:0])
gid_period_i  in  CW  tiles per GID word (DATAW/GW); 0 treated as 1
gid_base_i  in  AW  GIDX_ADDR
zeros_base_i  in  AW  ZEROS_ADDR
wq_base_i  in  AW  W_ADDR
wq_stride_i  in  AW  byte step per tile for Wq
gid_ready_i / zeros_ready_i / wq_ready_i  in  1 each  streamer ready_start
gid_done_i / zeros_done_i / wq_done_i  in  1 each  streamer done pulse
gid_req_o / zeros_req_o / wq_req_o  out  1 each  req_start
gid_addr_o / zeros_addr_o / wq_addr_o  out  AW each  addressgen base_addr
tile_idx_o  out  CW  current tile
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle sweep-complete pulse

Behaviour:
- Reset/clear: state IDLE, all counters/offsets 0, all outputs 0, addr outputs = bases + 0 (combinational from bases and registered offsets).
- States: IDLE, GID_REQ, GID_WAIT, ZQ_REQ, ZQ_WAIT, NEXT, FIN.
- IDLE: start_i latches n_tiles_i, gid_period_i (0 -> 1). If n_tiles==0 -> FIN, else -> GID_REQ. start_i ignored in every other state.
- GID_REQ: gid_req_o = gid_ready_i (combinational, same cycle); on issue -> GID_WAIT.
- GID_WAIT: on gid_done_i -> ZQ_REQ.
- ZQ_REQ: zeros_req_o = wq_req_o = zeros_ready_i && wq_ready_i; both issued together, never one alone; on issue -> ZQ_WAIT, clear done-seen flags.
- ZQ_WAIT: sticky flags capture zeros_done_i, wq_done_i; leave when both set (including same-cycle arrival, or one on the issue cycle+1 and the other later) -> NEXT.
- NEXT (1 cycle): if tile == n_tiles-1 -> FIN. Else tile+=1, zeros_offs+=JMP, wq_offs+=wq_stride; gid_sub+=1; if gid_sub reaches period-1 before increment: gid_sub=0, gid_offs+=JMP, -> GID_REQ; else -> ZQ_REQ.
- FIN: done_o=1 for this cycle; counters/offsets reset to 0; -> IDLE.
- busy_o = state != IDLE.
- Addresses: gid_addr_o = gid_base_i+gid_offs; zeros_addr_o = zeros_base_i+zeros_offs; wq_addr_o = wq_base_i+wq_offs; all modulo 2^AW, stable while a req is pending.
- Done pulses outside their WAIT window are ignored (no state change, not latched).
- clear_i mid-sweep: return to IDLE next cycle, no done_o, no further reqs.
- Minimum latency per tile without GID reload: ZQ_REQ, ZQ_WAIT (>=1 cycle), NEXT -> 3 cycles plus streamer time.
- tile_idx_o = tile counter register.

Decomposition:
- Package redmule_pkg: dequant_state_e enum; JMP derived constant reused from memory-scheduler math.
- No sub-module needed; optional small redmule_done_join (two sticky flags, clear on issue) if reused elsewhere.

Test Plan:
- n_tiles=4, period=2, readies high, done 3 cycles after req -> gid_req at tiles 0,2 only; gid_addr base, base+32; wq_addr base+0,s,2s,3s; one done_o after tile 3.
- n_tiles=0, start -> done_o pulse on 2nd cycle, no req ever asserted, busy_o high 1 cycle.
- ZQ_REQ with zeros_ready=1, wq_ready=0 for 5 cycles -> no zeros_req/wq_req; both assert in same cycle wq_ready rises.
- zeros_done and wq_done same cycle vs 4 cycles apart -> NEXT entered exactly once each tile, no skipped tile.
- clear_i asserted in ZQ_WAIT of tile 1 -> IDLE next cycle, offsets 0, no done_o; new start runs from tile 0.
- period_i=0, n_tiles=3 -> GID reloaded every tile (treated as 1): gid_addr base, +32, +64.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types and constants for the
// RedMulE dequantization scheduler.
package redmule_pkg;

  localparam int unsigned MEM_DW   = 32;
  localparam int unsigned DATA_W   = 288;
  localparam int unsigned NUM_BYTE = MEM_DW / 8;
  localparam int unsigned DQ_JMP   =
    NUM_BYTE * (DATA_W / MEM_DW - 1);

  typedef enum logic [2:0] {
    DQ_IDLE     = 3'd0,
    DQ_GID_REQ  = 3'd1,
    DQ_GID_WAIT = 3'd2,
    DQ_ZQ_REQ   = 3'd3,
    DQ_ZQ_WAIT  = 3'd4,
    DQ_NEXT     = 3'd5,
    DQ_FIN      = 3'd6
  } dequant_state_e;

endpackage

// File: rtl/redmule_done_join.sv
// Joins two done pulses with sticky flags;
// flags are dropped whenever a new pair is issued.
module redmule_done_join (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic arm_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic both_o
);

  logic a_q, a_d;
  logic b_q, b_d;

  // capture pulses only inside the wait window
  always_comb begin
    a_d = a_q | (en_i & a_i);
    b_d = b_q | (en_i & b_i);
    if (clear_i || arm_i) begin
      a_d = 1'b0;
      b_d = 1'b0;
    end
  end

  // flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign both_o = en_i & (a_q | a_i) & (b_q | b_i);

endmodule

// File: rtl/redmule_dequant_scheduler.sv
// Tile-by-tile sequencer for the GID, zeros
// and Wq dequant stream sources.
module redmule_dequant_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned CW  = 16,
  parameter int unsigned JMP = DQ_JMP
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic [CW-1:0] n_tiles_i,
  input  logic [CW-1:0] gid_period_i,
  input  logic [AW-1:0] gid_base_i,
  input  logic [AW-1:0] zeros_base_i,
  input  logic [AW-1:0] wq_base_i,
  input  logic [AW-1:0] wq_stride_i,
  input  logic          gid_ready_i,
  input  logic          zeros_ready_i,
  input  logic          wq_ready_i,
  input  logic          gid_done_i,
  input  logic          zeros_done_i,
  input  logic          wq_done_i,
  output logic          gid_req_o,
  output logic          zeros_req_o,
  output logic          wq_req_o,
  output logic [AW-1:0] gid_addr_o,
  output logic [AW-1:0] zeros_addr_o,
  output logic [AW-1:0] wq_addr_o,
  output logic [CW-1:0] tile_idx_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0] JmpW = AW'(JMP);

  dequant_state_e state_q, state_d;
  logic [CW-1:0] tile_q, tile_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] sub_q, sub_d;
  logic [AW-1:0] gid_offs_q, gid_offs_d;
  logic [AW-1:0] zeros_offs_q, zeros_offs_d;
  logic [AW-1:0] wq_offs_q, wq_offs_d;
  logic gid_issue, zq_issue, zq_both;

  assign gid_issue = (state_q == DQ_GID_REQ)
                   & gid_ready_i;
  assign zq_issue  = (state_q == DQ_ZQ_REQ)
                   & zeros_ready_i & wq_ready_i;

  assign gid_req_o    = gid_issue;
  assign zeros_req_o  = zq_issue;
  assign wq_req_o     = zq_issue;
  assign gid_addr_o   = gid_base_i + gid_offs_q;
  assign zeros_addr_o = zeros_base_i + zeros_offs_q;
  assign wq_addr_o    = wq_base_i + wq_offs_q;
  assign tile_idx_o   = tile_q;
  assign busy_o       = (state_q != DQ_IDLE);
  assign done_o       = (state_q == DQ_FIN);

  redmule_done_join i_join (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .arm_i  (zq_issue),
    .en_i   (state_q == DQ_ZQ_WAIT),
    .a_i    (zeros_done_i),
    .b_i    (wq_done_i),
    .both_o (zq_both)
  );

  // sweep sequencing and offset stepping
  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    n_d          = n_q;
    per_d        = per_q;
    sub_d        = sub_q;
    gid_offs_d   = gid_offs_q;
    zeros_offs_d = zeros_offs_q;
    wq_offs_d    = wq_offs_q;
    unique case (state_q)
      DQ_IDLE: if (start_i) begin
        n_d     = n_tiles_i;
        per_d   = (gid_period_i == '0) ?
                  CW'(1) : gid_period_i;
        state_d = (n_tiles_i == '0) ?
                  DQ_FIN : DQ_GID_REQ;
      end
      DQ_GID_REQ:
        if (gid_issue) state_d = DQ_GID_WAIT;
      DQ_GID_WAIT:
        if (gid_done_i) state_d = DQ_ZQ_REQ;
      DQ_ZQ_REQ:
        if (zq_issue) state_d = DQ_ZQ_WAIT;
      DQ_ZQ_WAIT:
        if (zq_both) state_d = DQ_NEXT;
      DQ_NEXT: begin
        if (tile_q == n_q - CW'(1)) begin
          state_d = DQ_FIN;
        end else begin
          tile_d       = tile_q + CW'(1);
          zeros_offs_d = zeros_offs_q + JmpW;
          wq_offs_d    = wq_offs_q + wq_stride_i;
          if (sub_q == per_q - CW'(1)) begin
            sub_d      = '0;
            gid_offs_d = gid_offs_q + JmpW;
            state_d    = DQ_GID_REQ;
          end else begin
            sub_d   = sub_q + CW'(1);
            state_d = DQ_ZQ_REQ;
          end
        end
      end
      DQ_FIN: begin
        tile_d       = '0;
        n_d          = '0;
        per_d        = '0;
        sub_d        = '0;
        gid_offs_d   = '0;
        zeros_offs_d = '0;
        wq_offs_d    = '0;
        state_d      = DQ_IDLE;
      end
      default: state_d = DQ_IDLE;
    endcase
    if (clear_i) begin
      tile_d       = '0;
      n_d          = '0;
      per_d        = '0;
      sub_d        = '0;
      gid_offs_d   = '0;
      zeros_offs_d = '0;
      wq_offs_d    = '0;
      state_d      = DQ_IDLE;
    end
  end

  // state and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DQ_IDLE;
      tile_q       <= '0;
      n_q          <= '0;
      per_q        <= '0;
      sub_q        <= '0;
      gid_offs_q   <= '0;
      zeros_offs_q <= '0;
      wq_offs_q    <= '0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      n_q          <= n_d;
      per_q        <= per_d;
      sub_q        <= sub_d;
      gid_offs_q   <= gid_offs_d;
      zeros_offs_q <= zeros_offs_d;
      wq_offs_q    <= wq_offs_d;
    end
  end

endmodule

// File: tb/tb_redmule_dequant_scheduler.sv
// Randomized bench for the dequant scheduler
// against a transaction-level reference model.
module tb_redmule_dequant_scheduler;

  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int JMP = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] n_tiles_i = '0;
  logic [CW-1:0] gid_period_i = '0;
  logic [AW-1:0] gid_base_i = '0;
  logic [AW-1:0] zeros_base_i = '0;
  logic [AW-1:0] wq_base_i = '0;
  logic [AW-1:0] wq_stride_i = '0;
  logic          gid_ready_i = 1'b0;
  logic          zeros_ready_i = 1'b0;
  logic          wq_ready_i = 1'b0;
  logic          gid_done_i = 1'b0;
  logic          zeros_done_i = 1'b0;
  logic          wq_done_i = 1'b0;
  logic          gid_req_o, zeros_req_o, wq_req_o;
  logic [AW-1:0] gid_addr_o, zeros_addr_o, wq_addr_o;
  logic [CW-1:0] tile_idx_o;
  logic          busy_o, done_o;

  redmule_dequant_scheduler #(
    .AW (AW),
    .CW (CW),
    .JMP(JMP)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .n_tiles_i    (n_tiles_i),
    .gid_period_i (gid_period_i),
    .gid_base_i   (gid_base_i),
    .zeros_base_i (zeros_base_i),
    .wq_base_i    (wq_base_i),
    .wq_stride_i  (wq_stride_i),
    .gid_ready_i  (gid_ready_i),
    .zeros_ready_i(zeros_ready_i),
    .wq_ready_i   (wq_ready_i),
    .gid_done_i   (gid_done_i),
    .zeros_done_i (zeros_done_i),
    .wq_done_i    (wq_done_i),
    .gid_req_o    (gid_req_o),
    .zeros_req_o  (zeros_req_o),
    .wq_req_o     (wq_req_o),
    .gid_addr_o   (gid_addr_o),
    .zeros_addr_o (zeros_addr_o),
    .wq_addr_o    (wq_addr_o),
    .tile_idx_o   (tile_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = GID request, 1 = zeros+Wq request, 2 = sweep done
  typedef struct {
    int            kind;
    int            tile;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  earliest = 0;
  bit  running = 0;
  int  gd_at = -1, zd_at = -1, wd_at = -1;
  int  clr_at = -1;
  bit  do_start = 0;

  int  rdy_pct = 100, dmax = 4;
  int  fg = 0, fz = 0, fw = 0;
  int  blk = 0, clr_tile = -1;
  bit  spur = 0;

  logic [AW-1:0] obs_gid[$];
  logic [AW-1:0] obs_wq[$];
  int  obs_done, obs_req, obs_busy;
  int  zq_issue_cyc, zq_earl;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int dly(input int f);
    return (f > 0) ? f : int'($urandom_range(dmax, 1));
  endfunction

  // expected transaction list of a whole sweep
  task automatic build(input int n, input int p);
    int  pe;
    ev_t e;
    pe = (p == 0) ? 1 : p;
    q.delete();
    for (int t = 0; t < n; t++) begin
      if (t % pe == 0) begin
        e.kind = 0;
        e.tile = t;
        e.a0 = gid_base_i + AW'((t / pe) * JMP);
        e.a1 = '0;
        q.push_back(e);
      end
      e.kind = 1;
      e.tile = t;
      e.a0 = zeros_base_i + AW'(t * JMP);
      e.a1 = wq_base_i + wq_stride_i * AW'(t);
      q.push_back(e);
    end
    e.kind = 2;
    e.tile = 0;
    e.a0 = '0;
    e.a1 = '0;
    q.push_back(e);
  endtask

  task automatic drive();
    bit quiet;
    gid_ready_i   = ($urandom_range(99) < rdy_pct);
    zeros_ready_i = ($urandom_range(99) < rdy_pct);
    wq_ready_i    = ($urandom_range(99) < rdy_pct);
    if (q.size() > 0 && q[0].kind == 1 &&
        cyc >= earliest && blk > 0) begin
      zeros_ready_i = 1'b1;
      wq_ready_i = 1'b0;
      blk--;
    end
    quiet = (cyc > zd_at) && (cyc > wd_at);
    gid_done_i = (cyc == gd_at) ||
      (spur && cyc > gd_at && $urandom_range(9) == 0);
    zeros_done_i = (cyc == zd_at) ||
      (spur && quiet && $urandom_range(9) == 0);
    wq_done_i = (cyc == wd_at) ||
      (spur && quiet && $urandom_range(9) == 0);
    clear_i = (cyc == clr_at);
    start_i = do_start;
    if (!do_start && spur && running &&
        $urandom_range(19) == 0) begin
      start_i = 1'b1;
      n_tiles_i = CW'($urandom_range(7));
    end
  endtask

  task automatic check_update();
    bit eg, ez, ed, pend, was_run;
    int k, m;
    eg = 0; ez = 0; ed = 0; pend = 0;
    k = -1;
    was_run = running;
    if (q.size() > 0) begin
      k = q[0].kind;
      pend = (cyc >= earliest);
      if (k == 0) eg = pend && gid_ready_i;
      if (k == 1) ez = pend && zeros_ready_i && wq_ready_i;
      if (k == 2) ed = (cyc == earliest);
    end
    chk("gid_req", gid_req_o, eg);
    chk("zeros_req", zeros_req_o, ez);
    chk("wq_req", wq_req_o, ez);
    chk("done", done_o, ed);
    chk("busy", busy_o, running);
    if (pend && k == 0) begin
      chk("gid_addr", gid_addr_o, q[0].a0);
      chk("tile_g", tile_idx_o, q[0].tile);
    end
    if (pend && k == 1) begin
      chk("zeros_addr", zeros_addr_o, q[0].a0);
      chk("wq_addr", wq_addr_o, q[0].a1);
      chk("tile_z", tile_idx_o, q[0].tile);
    end
    if (!running) begin
      chk("idle_gaddr", gid_addr_o, gid_base_i);
      chk("idle_zaddr", zeros_addr_o, zeros_base_i);
      chk("idle_waddr", wq_addr_o, wq_base_i);
      chk("idle_tile", tile_idx_o, 0);
    end
    if (gid_req_o) obs_gid.push_back(gid_addr_o);
    if (wq_req_o) obs_wq.push_back(wq_addr_o);
    if (done_o) obs_done++;
    if (busy_o) obs_busy++;
    if (gid_req_o || zeros_req_o || wq_req_o) obs_req++;
    if (clear_i) begin
      q.delete();
      running = 0;
      gd_at = -1; zd_at = -1; wd_at = -1;
      clr_at = -1;
    end else if (eg) begin
      void'(q.pop_front());
      gd_at = cyc + dly(fg);
      earliest = gd_at + 1;
    end else if (ez) begin
      if (zq_issue_cyc < 0) begin
        zq_issue_cyc = cyc;
        zq_earl = earliest;
      end
      if (q[0].tile == clr_tile) clr_at = cyc + 1;
      void'(q.pop_front());
      zd_at = cyc + dly(fz);
      wd_at = cyc + dly(fw);
      m = (zd_at > wd_at) ? zd_at : wd_at;
      earliest = m + 2;
    end else if (ed) begin
      void'(q.pop_front());
      running = 0;
    end
    if (start_i && !was_run && !clear_i) begin
      build(int'(n_tiles_i), int'(gid_period_i));
      earliest = cyc + 1;
      running = 1;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk_i);
    check_update();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int p);
    int lim;
    obs_gid.delete();
    obs_wq.delete();
    obs_done = 0;
    obs_req = 0;
    obs_busy = 0;
    zq_issue_cyc = -1;
    zq_earl = 0;
    n_tiles_i = CW'(n);
    gid_period_i = CW'(p);
    do_start = 1;
    step();
    do_start = 0;
    lim = cyc + 3000;
    while (running && cyc < lim) step();
    if (running) begin
      checks++;
      failures++;
      $display("FAIL timeout cyc=%0d got=busy want=idle", cyc);
      clr_at = cyc;
      step();
    end
    repeat (2) step();
  endtask

  task automatic knobs(input int r, input int g,
                       input int z, input int w,
                       input bit s);
    rdy_pct = r; fg = g; fz = z; fw = w; spur = s;
    blk = 0; clr_tile = -1;
  endtask

  initial begin
    gid_base_i   = 32'h0000_0100;
    zeros_base_i = 32'h0000_4000;
    wq_base_i    = 32'h0000_1000;
    wq_stride_i  = 32'h0000_0040;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_tile", tile_idx_o, 0);
    chk("rst_gaddr", gid_addr_o, 32'h0000_0100);
    chk("rst_waddr", wq_addr_o, 32'h0000_1000);
    repeat (3) step();

    // four tiles, GID reload every second tile
    knobs(100, 3, 3, 3, 0);
    run(4, 2);
    chk("t1_gid_n", obs_gid.size(), 2);
    chk("t1_gid0", obs_gid[0], 32'h0000_0100);
    chk("t1_gid1", obs_gid[1], 32'h0000_0120);
    chk("t1_wq_n", obs_wq.size(), 4);
    chk("t1_wq1", obs_wq[1], 32'h0000_1040);
    chk("t1_wq3", obs_wq[3], 32'h0000_10c0);
    chk("t1_done", obs_done, 1);

    // empty sweep
    run(0, 2);
    chk("t2_done", obs_done, 1);
    chk("t2_req", obs_req, 0);
    chk("t2_busy", obs_busy, 1);

    // Wq not ready for five cycles
    knobs(100, 2, 2, 2, 0);
    blk = 5;
    run(2, 1);
    chk("t3_hold", zq_issue_cyc - zq_earl, 5);

    // same-cycle and staggered done pulses
    knobs(100, 1, 2, 2, 0);
    run(3, 1);
    chk("t4a_tiles", obs_wq.size(), 3);
    chk("t4a_done", obs_done, 1);
    knobs(100, 1, 1, 5, 0);
    run(3, 1);
    chk("t4b_tiles", obs_wq.size(), 3);
    chk("t4b_done", obs_done, 1);

    // clear during the wait of tile 1
    knobs(100, 3, 3, 3, 0);
    clr_tile = 1;
    run(4, 2);
    chk("t5_done", obs_done, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_tiles", obs_wq.size(), 2);
    clr_tile = -1;
    run(4, 2);
    chk("t5r_wq0", obs_wq[0], 32'h0000_1000);
    chk("t5r_done", obs_done, 1);

    // zero period reloads GID on every tile
    gid_base_i = 32'h0000_2000;
    knobs(100, 2, 2, 2, 0);
    run(3, 0);
    chk("t6_gid_n", obs_gid.size(), 3);
    chk("t6_gid0", obs_gid[0], 32'h0000_2000);
    chk("t6_gid1", obs_gid[1], 32'h0000_2020);
    chk("t6_gid2", obs_gid[2], 32'h0000_2040);

    // randomized sweeps with stray pulses
    for (int i = 0; i < 16; i++) begin
      gid_base_i   = $urandom;
      zeros_base_i = $urandom;
      wq_base_i    = $urandom;
      wq_stride_i  = $urandom;
      knobs(60, 0, 0, 0, 1);
      dmax = 4;
      if (i == 5) clr_tile = 0;
      run((i % 7 == 3) ? 0 : int'($urandom_range(6, 1)),
          int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
